// File: rtl/axis_move_sequencer_pkg.sv
// Shared types and default constants for the two-axis pick-and-place move sequencer.
// Homing sub-state encodings double as the calibration flag codes sent to the axis drivers.
package axis_move_sequencer_pkg;

  localparam logic [15:0] HOME_PULSE      = 16'd32768;
  localparam logic [15:0] ORIGIN_OFFSET   = 16'd400;
  localparam logic [15:0] SQUARE_PULSES   = 16'd200;
  localparam int unsigned READY_HOLDOFF   = 25000;
  localparam int unsigned DWELL_CYCLES    = 10_000_000;
  localparam int unsigned DEBOUNCE_CYCLES = 250_000;
  localparam int unsigned WAIT_TIMEOUT_LOG2 = 26;

  typedef enum logic [3:0] {
    ST_HOMING   = 4'd0,
    ST_IDLE     = 4'd1,
    ST_MOVE_SRC = 4'd2,
    ST_WAIT_SRC = 4'd3,
    ST_GRAB     = 4'd4,
    ST_MOVE_DST = 4'd5,
    ST_WAIT_DST = 4'd6,
    ST_RELEASE  = 4'd7,
    ST_ERROR    = 4'd8
  } seq_state_e;

  // Value of each sub-state is the flag code the axis driver expects.
  typedef enum logic [1:0] {
    H_DONE    = 2'd0,
    H_SEEK    = 2'd1,
    H_BACKOFF = 2'd2
  } home_state_e;

  function automatic logic [15:0] square_goal(input logic [2:0] idx,
                                              input logic [15:0] sq0,
                                              input logic [15:0] pitch);
    return sq0 + ({13'd0, idx} * pitch);
  endfunction

endpackage

// File: rtl/axis_move_sequencer_limit_debounce.sv
// Synchronizes a raw active-low limit switch and only passes a level change
// once it has been stable for DEBOUNCE_CYCLES clocks. Output is active-high.
module limit_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = axis_move_sequencer_pkg::DEBOUNCE_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic limit_n_i,
  output logic level_o
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic [31:0] cnt_q;
  logic        raw_active;

  assign raw_active = ~sync2_q;
  assign level_o    = level_q;

  // Synchronizers reset to the released (high) level so nothing looks pressed at reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      sync1_q <= limit_n_i;
      sync2_q <= sync1_q;
      if (raw_active == level_q) begin
        cnt_q <= 32'd0;
      end else if (cnt_q == DEBOUNCE_CYCLES - 1) begin
        level_q <= raw_active;
        cnt_q   <= 32'd0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/axis_move_sequencer.sv
// Top-level sequencer: homes both axes, then executes pick (source square) and
// place (destination square) moves with magnet dwell and motor-ready timeout.
module axis_move_sequencer #(
  parameter logic [15:0] HOME_PULSE        = axis_move_sequencer_pkg::HOME_PULSE,
  parameter logic [15:0] ORIGIN_OFFSET     = axis_move_sequencer_pkg::ORIGIN_OFFSET,
  parameter logic [15:0] SQUARE_PULSES     = axis_move_sequencer_pkg::SQUARE_PULSES,
  parameter int unsigned READY_HOLDOFF     = axis_move_sequencer_pkg::READY_HOLDOFF,
  parameter int unsigned DWELL_CYCLES      = axis_move_sequencer_pkg::DWELL_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES   = axis_move_sequencer_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned WAIT_TIMEOUT_LOG2 = axis_move_sequencer_pkg::WAIT_TIMEOUT_LOG2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        limit_x_n,
  input  logic        limit_y_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_src_file,
  input  logic [2:0]  cmd_src_rank,
  input  logic [2:0]  cmd_dst_file,
  input  logic [2:0]  cmd_dst_rank,
  output logic [1:0]  calib_flag_x,
  output logic [1:0]  calib_flag_y,
  output logic [15:0] goal_pulse_x,
  output logic [15:0] goal_pulse_y,
  input  logic        motor_ready_x,
  input  logic        motor_ready_y,
  output logic        magnet_en,
  output logic        homed,
  output logic        busy,
  output logic        error,
  output logic [3:0]  dbg_state
);

  import axis_move_sequencer_pkg::*;

  localparam logic [15:0] SQ0_PULSE  = HOME_PULSE + ORIGIN_OFFSET;
  localparam logic [31:0] WAIT_LIMIT = 32'd1 << WAIT_TIMEOUT_LOG2;

  // Command handshake: a command transfers on a clock edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is only high in IDLE, so nothing is queued.
  seq_state_e  state_q, state_d;
  home_state_e hx_q, hx_d, hy_q, hy_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] wait_q, wait_d;
  logic [15:0] goal_x_q, goal_x_d, goal_y_q, goal_y_d;
  logic [2:0]  src_file_q, src_file_d, src_rank_q, src_rank_d;
  logic [2:0]  dst_file_q, dst_file_d, dst_rank_q, dst_rank_d;
  logic        magnet_q, magnet_d;
  logic        homed_q, homed_d;
  logic        error_q, error_d;
  logic        cmd_ready_q;
  logic        busy_q;
  logic        lim_x, lim_y;
  logic        both_ready;

  limit_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_x (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .limit_n_i (limit_x_n),
    .level_o   (lim_x)
  );

  limit_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_y (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .limit_n_i (limit_y_n),
    .level_o   (lim_y)
  );

  assign both_ready = motor_ready_x & motor_ready_y;

  always_comb begin
    state_d    = state_q;
    hx_d       = hx_q;
    hy_d       = hy_q;
    hold_d     = hold_q;
    dwell_d    = dwell_q;
    wait_d     = wait_q;
    goal_x_d   = goal_x_q;
    goal_y_d   = goal_y_q;
    src_file_d = src_file_q;
    src_rank_d = src_rank_q;
    dst_file_d = dst_file_q;
    dst_rank_d = dst_rank_q;
    magnet_d   = magnet_q;
    homed_d    = homed_q;
    error_d    = error_q;

    unique case (state_q)
      ST_HOMING: begin
        if (hx_q == H_SEEK && lim_x)         hx_d = H_BACKOFF;
        else if (hx_q == H_BACKOFF && !lim_x) hx_d = H_DONE;
        if (hy_q == H_SEEK && lim_y)         hy_d = H_BACKOFF;
        else if (hy_q == H_BACKOFF && !lim_y) hy_d = H_DONE;
        // Both axes parked: give the drivers READY_HOLDOFF cycles before going live.
        if (hx_q == H_DONE && hy_q == H_DONE) begin
          if (hold_q == READY_HOLDOFF - 1) begin
            state_d = ST_IDLE;
            homed_d = 1'b1;
            hold_d  = 32'd0;
          end else begin
            hold_d = hold_q + 32'd1;
          end
        end
      end

      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          src_file_d = cmd_src_file;
          src_rank_d = cmd_src_rank;
          dst_file_d = cmd_dst_file;
          dst_rank_d = cmd_dst_rank;
          state_d    = ST_MOVE_SRC;
        end
      end

      ST_MOVE_SRC: begin
        goal_x_d = square_goal(src_file_q, SQ0_PULSE, SQUARE_PULSES);
        goal_y_d = square_goal(src_rank_q, SQ0_PULSE, SQUARE_PULSES);
        hold_d   = READY_HOLDOFF;
        wait_d   = 32'd0;
        state_d  = ST_WAIT_SRC;
      end

      ST_WAIT_SRC: begin
        if (hold_q == 32'd0 && both_ready) begin
          magnet_d = 1'b1;
          dwell_d  = 32'd0;
          state_d  = ST_GRAB;
        end else if (wait_q == WAIT_LIMIT) begin
          magnet_d = 1'b0;
          error_d  = 1'b1;
          state_d  = ST_ERROR;
        end else begin
          wait_d = wait_q + 32'd1;
          if (hold_q != 32'd0) hold_d = hold_q - 32'd1;
        end
      end

      ST_GRAB: begin
        if (dwell_q == DWELL_CYCLES - 1) begin
          dwell_d = 32'd0;
          state_d = ST_MOVE_DST;
        end else begin
          dwell_d = dwell_q + 32'd1;
        end
      end

      ST_MOVE_DST: begin
        goal_x_d = square_goal(dst_file_q, SQ0_PULSE, SQUARE_PULSES);
        goal_y_d = square_goal(dst_rank_q, SQ0_PULSE, SQUARE_PULSES);
        hold_d   = READY_HOLDOFF;
        wait_d   = 32'd0;
        state_d  = ST_WAIT_DST;
      end

      ST_WAIT_DST: begin
        if (hold_q == 32'd0 && both_ready) begin
          magnet_d = 1'b0;
          dwell_d  = 32'd0;
          state_d  = ST_RELEASE;
        end else if (wait_q == WAIT_LIMIT) begin
          magnet_d = 1'b0;
          error_d  = 1'b1;
          state_d  = ST_ERROR;
        end else begin
          wait_d = wait_q + 32'd1;
          if (hold_q != 32'd0) hold_d = hold_q - 32'd1;
        end
      end

      ST_RELEASE: begin
        if (dwell_q == DWELL_CYCLES - 1) begin
          dwell_d = 32'd0;
          state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q + 32'd1;
        end
      end

      ST_ERROR: begin
        magnet_d = 1'b0;
        error_d  = 1'b1;
      end

      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_HOMING;
      hx_q        <= H_SEEK;
      hy_q        <= H_SEEK;
      hold_q      <= 32'd0;
      dwell_q     <= 32'd0;
      wait_q      <= 32'd0;
      goal_x_q    <= HOME_PULSE;
      goal_y_q    <= HOME_PULSE;
      src_file_q  <= 3'd0;
      src_rank_q  <= 3'd0;
      dst_file_q  <= 3'd0;
      dst_rank_q  <= 3'd0;
      magnet_q    <= 1'b0;
      homed_q     <= 1'b0;
      error_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hx_q        <= hx_d;
      hy_q        <= hy_d;
      hold_q      <= hold_d;
      dwell_q     <= dwell_d;
      wait_q      <= wait_d;
      goal_x_q    <= goal_x_d;
      goal_y_q    <= goal_y_d;
      src_file_q  <= src_file_d;
      src_rank_q  <= src_rank_d;
      dst_file_q  <= dst_file_d;
      dst_rank_q  <= dst_rank_d;
      magnet_q    <= magnet_d;
      homed_q     <= homed_d;
      error_q     <= error_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end
  end

  assign calib_flag_x = hx_q;
  assign calib_flag_y = hy_q;
  assign goal_pulse_x = goal_x_q;
  assign goal_pulse_y = goal_y_q;
  assign magnet_en    = magnet_q;
  assign homed        = homed_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign cmd_ready    = cmd_ready_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_axis_move_sequencer.sv
// Directed bench for axis_move_sequencer with shortened timing parameters:
// homing, a full pick/place move, ready holdoff, wait timeout and reset mid-grab.
module tb_axis_move_sequencer;
  import axis_move_sequencer_pkg::*;

  localparam int unsigned T_HOLD  = 20;
  localparam int unsigned T_DWELL = 16;
  localparam int unsigned T_DEB   = 8;
  localparam int unsigned T_TLOG2 = 10;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        limit_x_n, limit_y_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_src_file, cmd_src_rank, cmd_dst_file, cmd_dst_rank;
  logic [1:0]  calib_flag_x, calib_flag_y;
  logic [15:0] goal_pulse_x, goal_pulse_y;
  logic        motor_ready_x, motor_ready_y;
  logic        magnet_en, homed, busy, error;
  logic [3:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int n;

  axis_move_sequencer #(
    .HOME_PULSE        (16'd32768),
    .ORIGIN_OFFSET     (16'd400),
    .SQUARE_PULSES     (16'd200),
    .READY_HOLDOFF     (T_HOLD),
    .DWELL_CYCLES      (T_DWELL),
    .DEBOUNCE_CYCLES   (T_DEB),
    .WAIT_TIMEOUT_LOG2 (T_TLOG2)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .limit_x_n     (limit_x_n),
    .limit_y_n     (limit_y_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_src_file  (cmd_src_file),
    .cmd_src_rank  (cmd_src_rank),
    .cmd_dst_file  (cmd_dst_file),
    .cmd_dst_rank  (cmd_dst_rank),
    .calib_flag_x  (calib_flag_x),
    .calib_flag_y  (calib_flag_y),
    .goal_pulse_x  (goal_pulse_x),
    .goal_pulse_y  (goal_pulse_y),
    .motor_ready_x (motor_ready_x),
    .motor_ready_y (motor_ready_y),
    .magnet_en     (magnet_en),
    .homed         (homed),
    .busy          (busy),
    .error         (error),
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic send_cmd(input logic [2:0] sf, input logic [2:0] sr,
                          input logic [2:0] df, input logic [2:0] dr);
    cmd_src_file = sf;
    cmd_src_rank = sr;
    cmd_dst_file = df;
    cmd_dst_rank = dr;
    cmd_valid    = 1'b1;
    tick();
    cmd_valid    = 1'b0;
  endtask

  // X pressed first, Y pressed half a window later; both released in the same order.
  task automatic home_axes(output int hold_n);
    int i;
    limit_x_n = 1'b0;
    repeat (5) tick();
    limit_y_n = 1'b0;
    repeat (20) tick();
    check("backoff_flag_x", 32'(calib_flag_x), 32'd2);
    check("backoff_flag_y", 32'(calib_flag_y), 32'd2);
    limit_x_n = 1'b1;
    repeat (5) tick();
    limit_y_n = 1'b1;
    for (i = 0; i < 100 && calib_flag_y != 2'd0; i++) tick();
    check("done_flag_y", 32'(calib_flag_y), 32'd0);
    check("done_flag_x", 32'(calib_flag_x), 32'd0);
    hold_n = 0;
    while (!homed && hold_n < 200) begin
      tick();
      hold_n++;
    end
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    limit_x_n     = 1'b1;
    limit_y_n     = 1'b1;
    cmd_valid     = 1'b0;
    cmd_src_file  = 3'd0;
    cmd_src_rank  = 3'd0;
    cmd_dst_file  = 3'd0;
    cmd_dst_rank  = 3'd0;
    motor_ready_x = 1'b0;
    motor_ready_y = 1'b0;
    repeat (3) tick();

    check("rst_flag_x", 32'(calib_flag_x), 32'd1);
    check("rst_flag_y", 32'(calib_flag_y), 32'd1);
    check("rst_goal_x", 32'(goal_pulse_x), 32'd32768);
    check("rst_goal_y", 32'(goal_pulse_y), 32'd32768);
    check("rst_magnet", 32'(magnet_en), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_homed", 32'(homed), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_HOMING));

    sys_rst_n = 1'b1;
    repeat (3) tick();
    check("seek_flag_x", 32'(calib_flag_x), 32'd1);
    check("homing_busy", 32'(busy), 32'd1);

    // 5-cycle glitch is shorter than the debounce window
    limit_x_n = 1'b0;
    repeat (5) tick();
    limit_x_n = 1'b1;
    repeat (20) tick();
    check("glitch_flag_x", 32'(calib_flag_x), 32'd1);

    home_axes(n);
    check("homed_holdoff", 32'(n), 32'(T_HOLD));
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Move (0,0) -> (7,7) with motor_ready stuck high through the goal change
    motor_ready_x = 1'b1;
    motor_ready_y = 1'b1;
    send_cmd(3'd0, 3'd0, 3'd7, 3'd7);
    check("accept_cmd_ready", 32'(cmd_ready), 32'd0);
    check("accept_state", 32'(dbg_state), 32'(ST_MOVE_SRC));
    tick();
    check("src_goal_x", 32'(goal_pulse_x), 32'd33168);
    check("src_goal_y", 32'(goal_pulse_y), 32'd33168);
    n = 0;
    while (!magnet_en && n < 200) begin
      tick();
      n++;
    end
    check("src_wait_len", 32'(n), 32'(T_HOLD + 1));
    check("grab_state", 32'(dbg_state), 32'(ST_GRAB));

    // Command pulsed while busy must be ignored
    send_cmd(3'd3, 3'd3, 3'd4, 3'd4);
    check("busy_cmd_state", 32'(dbg_state), 32'(ST_GRAB));
    check("busy_cmd_goal_x", 32'(goal_pulse_x), 32'd33168);
    n = 1;
    while (goal_pulse_x == 16'd33168 && n < 200) begin
      tick();
      n++;
    end
    check("grab_dwell_len", 32'(n), 32'(T_DWELL + 1));
    check("dst_goal_x", 32'(goal_pulse_x), 32'd34568);
    check("dst_goal_y", 32'(goal_pulse_y), 32'd34568);
    check("dst_magnet", 32'(magnet_en), 32'd1);

    // X ready long before Y: exit must wait for Y
    motor_ready_x = 1'b0;
    motor_ready_y = 1'b0;
    repeat (10) tick();
    motor_ready_x = 1'b1;
    repeat (100) tick();
    check("x_only_state", 32'(dbg_state), 32'(ST_WAIT_DST));
    check("x_only_magnet", 32'(magnet_en), 32'd1);
    motor_ready_y = 1'b1;
    tick();
    check("release_magnet", 32'(magnet_en), 32'd0);
    check("release_state", 32'(dbg_state), 32'(ST_RELEASE));
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("release_dwell_len", 32'(n), 32'(T_DWELL));
    check("idle_goal_x", 32'(goal_pulse_x), 32'd34568);
    check("idle_goal_y", 32'(goal_pulse_y), 32'd34568);
    check("idle2_busy", 32'(busy), 32'd0);

    // Same source and destination, then Y never ready at the destination
    send_cmd(3'd2, 3'd5, 3'd2, 3'd5);
    tick();
    check("same_src_goal_x", 32'(goal_pulse_x), 32'd33568);
    check("same_src_goal_y", 32'(goal_pulse_y), 32'd34168);
    n = 0;
    while (!magnet_en && n < 200) begin
      tick();
      n++;
    end
    check("same_grab", 32'(magnet_en), 32'd1);
    motor_ready_y = 1'b0;
    n = 0;
    while (dbg_state != 4'(ST_WAIT_DST) && n < 200) begin
      tick();
      n++;
    end
    check("same_wait_dst", 32'(dbg_state), 32'(ST_WAIT_DST));
    check("same_dst_goal_x", 32'(goal_pulse_x), 32'd33568);
    n = 0;
    while (!error && n < 3000) begin
      tick();
      n++;
    end
    check("timeout_len", 32'(n), 32'((1 << T_TLOG2) + 1));
    check("err_magnet", 32'(magnet_en), 32'd0);
    check("err_cmd_ready", 32'(cmd_ready), 32'd0);
    check("err_busy", 32'(busy), 32'd0);
    check("err_goal_y", 32'(goal_pulse_y), 32'd34168);
    motor_ready_y = 1'b1;
    send_cmd(3'd1, 3'd1, 3'd2, 3'd2);
    repeat (3) tick();
    check("err_sticky_state", 32'(dbg_state), 32'(ST_ERROR));
    check("err_sticky_ready", 32'(cmd_ready), 32'd0);

    // Only reset leaves ERROR; rehome, then reset again in the middle of GRAB
    sys_rst_n = 1'b0;
    tick();
    check("err_reset_error", 32'(error), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) tick();
    home_axes(n);
    check("rehome_holdoff", 32'(n), 32'(T_HOLD));
    send_cmd(3'd1, 3'd2, 3'd4, 3'd6);
    n = 0;
    while (!magnet_en && n < 200) begin
      tick();
      n++;
    end
    check("grab2_magnet", 32'(magnet_en), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("midgrab_magnet", 32'(magnet_en), 32'd0);
    check("midgrab_flag_x", 32'(calib_flag_x), 32'd1);
    check("midgrab_flag_y", 32'(calib_flag_y), 32'd1);
    check("midgrab_state", 32'(dbg_state), 32'(ST_HOMING));
    tick();
    sys_rst_n = 1'b1;
    repeat (5) tick();
    check("restart_flag_x", 32'(calib_flag_x), 32'd1);
    check("restart_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
